aes_round_ctrl: RTL and testbench
=================================

// Module: aes_round_ctrl
// PURPOSE
//  Iterative AES encrypt round sequencer. Accepts one block per in_valid/in_ready handshake.
//  Drives the shared single-round datapath (SubBytes->ShiftRows->MixColumns->AddRoundKey)
//  through the initial key add, NR-1 full rounds and the final round (no MixColumns).
//  Presents the result on out_valid/out_ready. Stalls on the key-schedule round-key valid.
// PARAMETERS
//  NR      10  number of rounds; legal values 10/12/14 (AES-128/192/256)
//  RIDX_W  4   round index width; must hold NR
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  in_valid   in   1       plaintext block offered
//  in_ready   out  1       controller can accept a block
//  rk_valid   in   1       round key for round_idx is available this cycle
//  rk_req     out  1       request round key round_idx from key schedule
//  round_idx  out  RIDX_W  round whose key/operation is applied this cycle
//  st_load    out  1       load state reg with plaintext XOR rk[0]
//  st_en      out  1       state reg captures round datapath output
//  mix_en     out  1       1 = MixColumns in path; 0 = bypass (final round)
//  out_valid  out  1       state reg holds ciphertext
//  out_ready  in   1       consumer accepts ciphertext
//  busy       out  1       block in flight (not IDLE)
// BEHAVIOUR
//  Reset (async on rst_n=0, any state): state=IDLE, round_idx=0, in_ready=1, all other outputs 0.
//  FSM states: IDLE, INIT, ROUND, FINAL, DONE.
//  IDLE : in_ready=1, round_idx=0. in_valid&&in_ready -> INIT.
//  INIT : rk_req=1, round_idx=0; st_load=rk_valid. rk_valid -> ROUND, round_idx<=1; else hold.
//  ROUND: rk_req=1, mix_en=1, st_en=rk_valid. On rk_valid: round_idx++;
//         if round_idx==NR-1 -> FINAL. !rk_valid: hold all, st_en=0.
//  FINAL: rk_req=1, mix_en=0, round_idx=NR, st_en=rk_valid. rk_valid -> DONE.
//  DONE : out_valid=1, round_idx held at NR; out_ready -> IDLE, round_idx<=0.
//  Handshake: in_ready only in IDLE, combinational from state (no in_valid dependence).
//  out_valid is registered-state-decoded; stays 1 with stable data until out_ready.
//  in_valid in DONE is not accepted (in_ready=0); next accept is earliest the cycle after IDLE entry.
//  Latency (rk_valid=1 always): accept at edge T; INIT T+1; ROUND T+2..T+NR;
//    FINAL T+NR+1; out_valid from T+NR+2. NR=10: 12 cycles accept->out_valid; throughput 1 block / NR+3 cycles.
//  Each rk_valid=0 cycle in INIT/ROUND/FINAL adds exactly one cycle; no outputs change while stalled.
//  st_load, st_en, mix_en are mutually consistent: never st_load&&st_en; mix_en=0 outside ROUND.
//  round_idx never exceeds NR; counter increments only on ROUND/FINAL exits, never wraps.
//  Reset asserted mid-block: block discarded, no out_valid, returns to IDLE state values.
//  rk_valid outside INIT/ROUND/FINAL is ignored.
// STRUCTURE
//  aes_pkg: typedef enum logic [2:0] aes_ctrl_state_e {IDLE,INIT,ROUND,FINAL,DONE};
//    localparams AES128_NR=10, AES192_NR=12, AES256_NR=14; typedef logic [7:0] aes_state_t [0:3][0:3].
//  Single module: one state register, one round counter, output decode in always_comb.
//  No sub-module; datapath and key schedule sit outside and are wired at aes_core level.
// TESTING
//  1 Reset, in_valid=1 at T, rk_valid=1: st_load@T+1, st_en T+2..T+11, mix_en=0 only @T+11,
//    round_idx 0..10, out_valid@T+12.
//  2 Integrated with datapath+key schedule: key 000102..0e0f, pt 00112233..eeff
//    -> ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a.
//  3 rk_valid low 3 cycles during round 5: round_idx holds 5, st_en=0 those cycles,
//    out_valid 3 cycles later (T+15).
//  4 out_ready low 4 cycles in DONE: out_valid held, in_ready=0, in_valid ignored;
//    out_ready=1 -> IDLE next cycle, in_ready=1.
//  5 rst_n pulsed low at round 7: all outputs at reset values immediately (async),
//    no out_valid follows; next block completes normally.
//  6 Back-to-back in_valid held high, NR=14 build: one accept per 17 cycles,
//    round_idx 0..14, never exceeds NR.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES types and constants used by the round controller and the datapath
// it sequences.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } aes_ctrl_state_e;

    localparam int AES128_NR = 10;
    localparam int AES192_NR = 12;
    localparam int AES256_NR = 14;

    typedef logic [7:0] aes_state_t [0:3][0:3];

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES encrypt round sequencer: steps an external single-round datapath
// through the initial key add, NR-1 full rounds and the final (no MixColumns) round.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR     = AES128_NR,
    parameter int RIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              rk_valid,
    output logic              rk_req,
    output logic [RIDX_W-1:0] round_idx,
    output logic              st_load,
    output logic              st_en,
    output logic              mix_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [RIDX_W-1:0] LAST_FULL_IDX = RIDX_W'(NR - 1);

    aes_ctrl_state_e   state_q, state_d;
    logic [RIDX_W-1:0] ridx_q, ridx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            ridx_q  <= ridx_d;
        end
    end

    // Every active state waits on rk_valid, so a missing key freezes state,
    // counter and all outputs except the capture strobes.
    always_comb begin
        state_d   = state_q;
        ridx_d    = ridx_q;
        in_ready  = 1'b0;
        rk_req    = 1'b0;
        st_load   = 1'b0;
        st_en     = 1'b0;
        mix_en    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = INIT;
                    ridx_d  = '0;
                end
            end
            INIT: begin
                rk_req  = 1'b1;
                st_load = rk_valid;
                if (rk_valid) begin
                    state_d = ROUND;
                    ridx_d  = RIDX_W'(1);
                end
            end
            ROUND: begin
                rk_req = 1'b1;
                mix_en = 1'b1;
                st_en  = rk_valid;
                if (rk_valid) begin
                    ridx_d = ridx_q + RIDX_W'(1);
                    if (ridx_q == LAST_FULL_IDX) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                rk_req = 1'b1;
                st_en  = rk_valid;
                if (rk_valid) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                    ridx_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ridx_d  = '0;
            end
        endcase
    end

    assign round_idx = ridx_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: cycle-exact strobe checks plus a behavioural
// AES-128 datapath/key schedule driven by the controller's strobes.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int RIDX_W = 4;
    localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // Expected flag patterns, bit order {in_ready,out_valid,busy,rk_req,st_load,st_en,mix_en}
    localparam logic [6:0] F_IDLE        = 7'b1000000;
    localparam logic [6:0] F_INIT_LD     = 7'b0011100;
    localparam logic [6:0] F_ROUND       = 7'b0011011;
    localparam logic [6:0] F_ROUND_STALL = 7'b0011001;
    localparam logic [6:0] F_FINAL       = 7'b0011010;
    localparam logic [6:0] F_DONE        = 7'b0110000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid, in_ready, rk_valid, rk_req, st_load, st_en, mix_en;
    logic              out_valid, out_ready, busy;
    logic [RIDX_W-1:0] round_idx;

    logic              iv14, ir14, rq14, ld14, en14, mx14, ov14, bz14;
    logic              rkv14, ordy14;
    logic [RIDX_W-1:0] idx14;

    aes_round_ctrl #(.NR(AES128_NR), .RIDX_W(RIDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .rk_valid(rk_valid), .rk_req(rk_req), .round_idx(round_idx),
        .st_load(st_load), .st_en(st_en), .mix_en(mix_en),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    aes_round_ctrl #(.NR(AES256_NR), .RIDX_W(RIDX_W)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv14), .in_ready(ir14),
        .rk_valid(rkv14), .rk_req(rq14), .round_idx(idx14),
        .st_load(ld14), .st_en(en14), .mix_en(mx14),
        .out_valid(ov14), .out_ready(ordy14), .busy(bz14)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural AES-128 datapath ----------------
    logic [7:0]   sb   [0:255];
    logic [127:0] rkey [0:15];
    logic [31:0]  w    [0:43];
    logic [127:0] dp_q;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic mix);
        logic [7:0]   a [0:15];
        logic [7:0]   b [0:15];
        logic [7:0]   m [0:15];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sb[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
        for (int c = 0; c < 4; c++) begin
            if (mix) begin
                m[4*c]   = gmul(8'h02, b[4*c]) ^ gmul(8'h03, b[4*c+1]) ^ b[4*c+2] ^ b[4*c+3];
                m[4*c+1] = b[4*c] ^ gmul(8'h02, b[4*c+1]) ^ gmul(8'h03, b[4*c+2]) ^ b[4*c+3];
                m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(8'h02, b[4*c+2]) ^ gmul(8'h03, b[4*c+3]);
                m[4*c+3] = gmul(8'h03, b[4*c]) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(8'h02, b[4*c+3]);
            end else begin
                for (int rr = 0; rr < 4; rr++) m[4*c+rr] = b[4*c+rr];
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i] ^ k[127-8*i -: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (st_load)    dp_q <= PT ^ rkey[round_idx];
        else if (st_en) dp_q <= aes_round(dp_q, rkey[round_idx], mix_en);
    end

    // ---------------- helpers ----------------
    function automatic logic [127:0] obs10();
        return 128'({in_ready, out_valid, busy, rk_req, st_load, st_en, mix_en, round_idx});
    endfunction

    function automatic logic [127:0] mk(input logic [6:0] f, input logic [RIDX_W-1:0] idx);
        return 128'({f, idx});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_done();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int             blk = 0;
    logic [127:0]   e;
    logic           bad;
    int             acc[$];
    logic [RIDX_W-1:0] max14;

    initial begin
        logic [31:0] t;
        logic [7:0]  rc;

        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        for (int i = 0; i < 4; i++) w[i] = KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rkey[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;

        in_valid = 1'b0; rk_valid = 1'b1; out_ready = 1'b0;
        iv14 = 1'b0; rkv14 = 1'b1; ordy14 = 1'b1;

        #1 rst_n = 1'b0;
        #1 check("reset", obs10(), mk(F_IDLE, '0));
        #20 rst_n = 1'b1;
        tick();

        // Nominal block: strobe timeline and known-answer ciphertext
        start_block();
        for (int k = 1; k <= 12; k++) begin
            if (k == 1)       e = mk(F_INIT_LD, '0);
            else if (k <= 10) e = mk(F_ROUND, RIDX_W'(k-1));
            else if (k == 11) e = mk(F_FINAL, RIDX_W'(10));
            else              e = mk(F_DONE, RIDX_W'(10));
            check($sformatf("t1_k%0d", k), obs10(), e);
            if (k < 12) tick();
        end
        check("t1_ct", dp_q, CT);
        blk++;
        $display("block %0d: nominal, ct=%h", blk, dp_q);

        // Consumer back-pressure in DONE with a competing in_valid
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t4_hold%0d", k), obs10(), mk(F_DONE, RIDX_W'(10)));
            check($sformatf("t4_ct%0d", k), dp_q, CT);
        end
        out_ready = 1'b1;
        tick();
        check("t4_idle", obs10(), mk(F_IDLE, '0));
        in_valid = 1'b0;
        out_ready = 1'b0;
        $display("block %0d: released after 4 stalled cycles", blk);

        // Key-schedule stall for 3 cycles in round 5
        start_block();
        for (int k = 1; k <= 15; k++) begin
            rk_valid = (k >= 6 && k <= 8) ? 1'b0 : 1'b1;
            #1;
            if (k == 1)       e = mk(F_INIT_LD, '0);
            else if (k <= 5)  e = mk(F_ROUND, RIDX_W'(k-1));
            else if (k <= 8)  e = mk(F_ROUND_STALL, RIDX_W'(5));
            else if (k <= 13) e = mk(F_ROUND, RIDX_W'(k-4));
            else if (k == 14) e = mk(F_FINAL, RIDX_W'(10));
            else              e = mk(F_DONE, RIDX_W'(10));
            check($sformatf("t3_k%0d", k), obs10(), e);
            if (k < 15) tick();
        end
        check("t3_ct", dp_q, CT);
        blk++;
        $display("block %0d: rk stall, ct=%h", blk, dp_q);
        rk_valid = 1'b1;
        release_done();

        // Asynchronous reset during round 7 discards the block
        start_block();
        for (int k = 1; k < 8; k++) tick();
        check("t5_pre", obs10(), mk(F_ROUND, RIDX_W'(7)));
        rst_n = 1'b0;
        #1;
        check("t5_async", obs10(), mk(F_IDLE, '0));
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (out_valid || busy) bad = 1'b1;
        end
        check("t5_no_ov", 128'(bad), 128'(1'b0));
        $display("block %0d: aborted by reset", blk + 1);
        start_block();
        for (int k = 1; k < 11; k++) tick();
        check("t5_k11", obs10(), mk(F_FINAL, RIDX_W'(10)));
        tick();
        check("t5_k12", obs10(), mk(F_DONE, RIDX_W'(10)));
        check("t5_ct", dp_q, CT);
        blk++;
        $display("block %0d: after reset, ct=%h", blk, dp_q);
        release_done();

        // NR=14 instance with in_valid and out_ready held high
        max14 = '0;
        iv14 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (ir14) acc.push_back(c);
            if (idx14 > max14) max14 = idx14;
            tick();
        end
        iv14 = 1'b0;
        check("t6_accepts", 128'(acc.size()), 128'(4));
        for (int i = 1; i < acc.size(); i++)
            check($sformatf("t6_period%0d", i), 128'(acc[i] - acc[i-1]), 128'(17));
        check("t6_max_idx", 128'(max14), 128'(14));
        $display("nr14: %0d accepts in 60 cycles, max round_idx %0d", acc.size(), max14);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
